snn_spike_sequencer: RTL

//  Controller that drives a small spiking-neuron network (e.g. the 2-input AND net).

---
 rtl/snn_pkg.sv | 29 ++
 rtl/snn_spike_counter.sv | 46 ++++
 rtl/snn_spike_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network spike sequencer.
//   state_e   : controller FSM states
//   DEF_*     : default parameter values used by the top and the counter
//   sat_inc() : saturating increment of a counter value of a given bit width
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    GAP,
    SETTLE,
    DONE
  } state_e;

  localparam int unsigned DEF_NUM_IN       = 2;
  localparam int unsigned DEF_NUM_BURST    = 4;
  localparam int unsigned DEF_GAP_CYC      = 2;
  localparam int unsigned DEF_SETTLE_CYC   = 5;
  localparam int unsigned DEF_STAGGER_LAST = 1;
  localparam int unsigned DEF_CNT_W        = 4;

  // Increment cnt, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating spike counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one spike this cycle
//   cnt        : registered count
//   cnt_nxt    : value cnt takes at the next edge (lets the parent latch a
//                result in the same cycle as the final increment)
module snn_spike_counter
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/snn_spike_sequencer.sv
// Spike-train controller for a small spiking-neuron network.
// Accepts an input bit vector over valid/ready, fires NUM_BURST rounds of
// one-cycle spikes (bit=1 -> spk_p, bit=0 -> spk_n), each followed by GAP_CYC
// idle cycles, keeps counting for SETTLE_CYC more cycles, then presents the
// counted net_p/net_n spikes and a decided result bit until res_ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   abort               : return to IDLE from any busy state, no result
//   in_valid/in_ready   : request handshake, in_bits captured on it
//   spk_p, spk_n        : per-input positive/negative spikes to the network
//   net_p, net_n        : network output spikes being counted
//   res_valid/res_ready : result handshake
//   res_bit, res_none   : p_cnt > n_cnt, and both counts zero
//   res_p_cnt/res_n_cnt : saturated spike counts
//   busy                : controller not in IDLE
// Every output is a flop; outputs are computed from the next-state values.
module snn_spike_sequencer
  import snn_pkg::*;
#(
  parameter int unsigned NUM_IN       = DEF_NUM_IN,
  parameter int unsigned NUM_BURST    = DEF_NUM_BURST,
  parameter int unsigned GAP_CYC      = DEF_GAP_CYC,
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned STAGGER_LAST = DEF_STAGGER_LAST,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_bits,
  output logic [NUM_IN-1:0] spk_p,
  output logic [NUM_IN-1:0] spk_n,
  input  logic              net_p,
  input  logic              net_n,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_bit,
  output logic              res_none,
  output logic [CNT_W-1:0]  res_p_cnt,
  output logic [CNT_W-1:0]  res_n_cnt,
  output logic              busy
);

  localparam int unsigned RND_W = $clog2(NUM_BURST + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned STG_W = $clog2(NUM_IN + 1);

  localparam logic [RND_W-1:0] LAST_RND   = RND_W'(NUM_BURST - 1);
  localparam logic [GAP_W-1:0] LAST_GAP   = GAP_W'(GAP_CYC - 1);
  localparam logic [SET_W-1:0] LAST_SET   = SET_W'(SETTLE_CYC - 1);
  localparam logic [STG_W-1:0] LAST_STG   = STG_W'(NUM_IN - 1);
  localparam bit               STAGGER_EN = (STAGGER_LAST != 0);

  // Control state
  state_e            state_q,  state_d;
  logic [RND_W-1:0]  round_q,  round_d;
  logic [GAP_W-1:0]  gap_q,    gap_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [STG_W-1:0]  stg_q,    stg_d;
  logic [NUM_IN-1:0] bits_q,   bits_d;

  // Registered outputs
  logic              in_ready_q,  in_ready_d;
  logic [NUM_IN-1:0] spk_p_q,     spk_p_d;
  logic [NUM_IN-1:0] spk_n_q,     spk_n_d;
  logic              res_valid_q, res_valid_d;
  logic              res_bit_q,   res_bit_d;
  logic              res_none_q,  res_none_d;
  logic [CNT_W-1:0]  res_p_cnt_q, res_p_cnt_d;
  logic [CNT_W-1:0]  res_n_cnt_q, res_n_cnt_d;
  logic              busy_q,      busy_d;

  logic              handshake;
  logic              load_res;
  logic              sample_en;
  logic              stagger_now;
  logic [NUM_IN-1:0] fire_mask;
  logic [CNT_W-1:0]  p_cnt, p_cnt_nxt;
  logic [CNT_W-1:0]  n_cnt, n_cnt_nxt;

  // Network outputs are observed only while a request is in flight; an
  // aborting cycle is not counted so the counters hold on abort.
  assign sample_en = ((state_q == FIRE) || (state_q == GAP) || (state_q == SETTLE)) && !abort;

  snn_spike_counter #(.CNT_W(CNT_W)) u_p_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (handshake),
    .en      (net_p && sample_en),
    .cnt     (p_cnt),
    .cnt_nxt (p_cnt_nxt)
  );

  snn_spike_counter #(.CNT_W(CNT_W)) u_n_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (handshake),
    .en      (net_n && sample_en),
    .cnt     (n_cnt),
    .cnt_nxt (n_cnt_nxt)
  );

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    gap_d     = gap_q;
    settle_d  = settle_q;
    stg_d     = stg_q;
    bits_d    = bits_q;
    handshake = 1'b0;
    load_res  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // in_ready_q rather than the state alone: in_ready comes out of
        // reset low for one cycle and the handshake must match the port.
        if (in_ready_q && in_valid) begin
          handshake = 1'b1;
          bits_d    = in_bits;
          round_d   = '0;
          stg_d     = '0;
          state_d   = FIRE;
        end
      end
      FIRE: begin
        // The staggered last round stays in FIRE for one cycle per input.
        if (STAGGER_EN && (round_q == LAST_RND) && (stg_q != LAST_STG)) begin
          stg_d = stg_q + 1'b1;
        end else begin
          stg_d   = '0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) begin
          if (round_q == LAST_RND) begin
            settle_d = '0;
            state_d  = SETTLE;
          end else begin
            round_d = round_q + 1'b1;
            state_d = FIRE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      SETTLE: begin
        if (settle_q == LAST_SET) begin
          state_d  = DONE;
          load_res = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including res_ready and the result load.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      load_res = 1'b0;
    end
  end

  // Output logic, evaluated on the next state so the flops present it in
  // the cycle that state is active.
  always_comb begin
    stagger_now = STAGGER_EN && (round_d == LAST_RND);
    fire_mask   = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (state_d == FIRE) begin
        fire_mask[i] = !stagger_now || (stg_d == STG_W'(i));
      end
    end

    spk_p_d     = bits_d & fire_mask;
    spk_n_d     = ~bits_d & fire_mask;
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == DONE);

    res_bit_d   = res_bit_q;
    res_none_d  = res_none_q;
    res_p_cnt_d = res_p_cnt_q;
    res_n_cnt_d = res_n_cnt_q;
    // Latch from the counters' next values so the last settle sample counts.
    if (load_res) begin
      res_p_cnt_d = p_cnt_nxt;
      res_n_cnt_d = n_cnt_nxt;
      res_bit_d   = (p_cnt_nxt > n_cnt_nxt);
      res_none_d  = (p_cnt_nxt == '0) && (n_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      gap_q       <= '0;
      settle_q    <= '0;
      stg_q       <= '0;
      bits_q      <= '0;
      in_ready_q  <= 1'b0;
      spk_p_q     <= '0;
      spk_n_q     <= '0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      res_none_q  <= 1'b0;
      res_p_cnt_q <= '0;
      res_n_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      gap_q       <= gap_d;
      settle_q    <= settle_d;
      stg_q       <= stg_d;
      bits_q      <= bits_d;
      in_ready_q  <= in_ready_d;
      spk_p_q     <= spk_p_d;
      spk_n_q     <= spk_n_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      res_none_q  <= res_none_d;
      res_p_cnt_q <= res_p_cnt_d;
      res_n_cnt_q <= res_n_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign spk_p     = spk_p_q;
  assign spk_n     = spk_n_q;
  assign res_valid = res_valid_q;
  assign res_bit   = res_bit_q;
  assign res_none  = res_none_q;
  assign res_p_cnt = res_p_cnt_q;
  assign res_n_cnt = res_n_cnt_q;
  assign busy      = busy_q;

endmodule
